esw_in_arb: RTL and testbench
=============================

Name: esw_in_arb

Overview:
- Two-input, packet-level round-robin arbiter placed in front of the ESW ingress (pke input).
- Merges the LCM-local packet stream (input 0) and the host/CPU injection stream (input 1) into the single 134-bit ESW input stream.
- Inputs have no backpressure, so each input is buffered in its own packet FIFO.
- Whole packets are granted alternately; packets that cannot be fully buffered are dropped and counted.

Parameters:
DATA_DEPTH, 256, words per input data FIFO (power of 2)
VAL_DEPTH, 16, packet-descriptor entries per input (power of 2)
MAX_PKT_WORDS, 128, maximum packet length in 134-bit words; also the free-space reservation per packet

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
in0_data  in  134  input 0 word; [133:132] 01=head, 11=body, 10=tail
in0_data_wr  in  1  input 0 word strobe
in0_valid  in  1  input 0 packet good(1)/bad(0)
in0_valid_wr  in  1  input 0 valid strobe, coincident with tail word
in1_data, in1_data_wr, in1_valid, in1_valid_wr  in  134/1/1/1  same for input 1
out_data  out  134  merged word to ESW
out_data_wr  out  1  word strobe
out_valid  out  1  packet good flag
out_valid_wr  out  1  valid strobe, coincident with out tail word
drop_cnt0, drop_cnt1  out  32  packets dropped per input (no space)
err_cnt0, err_cnt1  out  32  framing errors per input (stray body/tail, oversize)
pkt_out_cnt  out  64  packets emitted

Behaviour:
- Reset (async, rst=1): all outputs 0; FIFOs emptied; counters 0; FSM to IDLE; RR pointer = input 0. A partially emitted packet is abandoned with no tail.
- Writer, per input, evaluated on the head word:
  - Accept only if data FIFO free words >= MAX_PKT_WORDS and the descriptor FIFO is not full.
  - Otherwise drop every word through the tail and increment drop_cntN.
- Body or tail word outside a packet: discard and increment err_cntN.
- Oversize packet (word count reaches MAX_PKT_WORDS before the tail):
  - Stop writing words; still write the tail word.
  - The tail counts as the last stored word, so at most MAX_PKT_WORDS words are stored.
  - Force descriptor valid=0 and increment err_cntN.
- Descriptor (1-bit valid) is pushed on the accepted tail cycle. A packet is eligible only once its descriptor is present.
- FSM IDLE:
  - If exactly one input has a descriptor, grant it.
  - If both have one, grant the RR-pointer input.
  - Register the grant and go to SEND.
- FSM SEND:
  - Read the granted data FIFO one word per cycle (1-cycle read latency). out_data/out_data_wr are registered.
  - On the tail word: pop the descriptor; drive out_valid = descriptor and out_valid_wr = 1 in the same cycle as the tail out_data_wr.
  - Set RR pointer to the other input, increment pkt_out_cnt, return to IDLE.
- Timing:
  - Packets are contiguous on the output (no gaps inside a packet).
  - Minimum 2 idle cycles between consecutive output packets.
  - Latency: input tail at cycle T with both FSM and FIFO idle gives output head out_data_wr at T+3.
- Simultaneous writes on both inputs are independent; neither is blocked.
- Simultaneous push and pop on the same FIFO: the free-space check uses the registered count, which is conservative; no overflow is possible.
- Counters wrap at 2^32 (pkt_out_cnt at 2^64).
- Data FIFO pointers wrap modulo DATA_DEPTH.

Decomposition:
- Shared package:
  - Header codes HDR_HEAD=2'b01, HDR_BODY=2'b11, HDR_TAIL=2'b10.
  - Word width 134.
  - FSM state encoding IDLE/SEND.
- One natural sub-module, `esw_in_pkt_fifo`: writer logic, data FIFO, descriptor FIFO and per-input counters. Instantiated twice.
- Top-level holds the arbiter FSM and output registers.

Test Plan:
- Single 4-word good packet on in0 (tail at cycle 10) -> out head at cycle 13, 4 contiguous words, out_valid_wr=1 with out_valid=1 on the 4th word, pkt_out_cnt=1.
- 3 packets queued on each input simultaneously -> output order 0,1,0,1,0,1, each packet contiguous, pkt_out_cnt=6.
- in1 packet with in1_valid=0 -> forwarded unchanged with out_valid=0 at its tail.
- Fill in0 while output is stalled behind a 100-word in1 packet:
  - Send 3x100-word packets on in0.
  - Third packet dropped (free < 128), drop_cnt0=1; first two are forwarded intact.
- Stray body word on in0 -> discarded, err_cnt0=1, no output. 130-word packet on in0 -> 128 words out, last one tail, out_valid=0, err_cnt0=2.
- Assert rst mid-SEND of a 10-word packet -> all outputs 0 immediately, counters 0. Next fresh packet forwarded correctly with in0 granted first.

Source files
------------

// File: rtl/esw_in_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : esw_in_arb_pkg
// Purpose  : Shared word width, header codes and arbiter state encoding.
// Revision : 1.0
// ============================================================================
package esw_in_arb_pkg;

    localparam int         c_WORD_W   = 134;
    localparam logic [1:0] c_HDR_HEAD = 2'b01;
    localparam logic [1:0] c_HDR_BODY = 2'b11;
    localparam logic [1:0] c_HDR_TAIL = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/esw_in_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : esw_in_pkt_fifo
// Purpose  : Per-input packet writer, data FIFO, descriptor FIFO and counters.
// Revision : 1.0
// ============================================================================
module esw_in_pkt_fifo
    import esw_in_arb_pkg::*;
#(
    parameter int DATA_DEPTH    = 256,
    parameter int VAL_DEPTH     = 16,
    parameter int MAX_PKT_WORDS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [c_WORD_W-1:0] i_data,
    input  logic                i_data_wr,
    input  logic                i_valid,
    input  logic                i_valid_wr,
    input  logic                i_rd_en,
    input  logic                i_desc_pop,
    output logic [c_WORD_W-1:0] o_rd_data,
    output logic                o_rd_is_tail,
    output logic                o_desc_avail,
    output logic                o_desc_val,
    output logic [31:0]         o_drop_cnt,
    output logic [31:0]         o_err_cnt
);
    localparam int                c_AW        = $clog2(DATA_DEPTH);
    localparam int                c_VW        = $clog2(VAL_DEPTH);
    localparam int                c_WC_W      = $clog2(MAX_PKT_WORDS) + 1;
    localparam logic [c_AW:0]     c_DEPTH_CNT = (c_AW+1)'(DATA_DEPTH);
    localparam logic [c_AW:0]     c_RESERVE   = (c_AW+1)'(MAX_PKT_WORDS);
    localparam logic [c_VW:0]     c_VAL_FULL  = (c_VW+1)'(VAL_DEPTH);
    localparam logic [c_WC_W-1:0] c_WC_LIMIT  = c_WC_W'(MAX_PKT_WORDS - 1);

    logic [c_WORD_W-1:0] r_mem [DATA_DEPTH];
    logic                r_vmem [VAL_DEPTH];
    logic [c_AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]       r_count;
    logic [c_VW-1:0]     r_vwr_ptr, r_vrd_ptr;
    logic [c_VW:0]       r_vcount;
    logic                r_in_pkt, r_dropping, r_oversize;
    logic [c_WC_W-1:0]   r_wcnt;
    logic [c_WORD_W-1:0] r_rd_data;
    logic [31:0]         r_drop_cnt, r_err_cnt;

    logic [1:0] w_hdr;
    logic       w_is_head, w_is_body, w_is_tail;
    logic       w_accept, w_wr, w_push, w_at_limit, w_desc_bit;

    assign w_hdr      = i_data[c_WORD_W-1 -: 2];
    assign w_is_head  = i_data_wr && (w_hdr == c_HDR_HEAD);
    assign w_is_body  = i_data_wr && (w_hdr == c_HDR_BODY);
    assign w_is_tail  = i_data_wr && (w_hdr == c_HDR_TAIL);
    // Room is judged on the registered count, so a same-cycle pop is ignored.
    assign w_accept   = w_is_head && ((c_DEPTH_CNT - r_count) >= c_RESERVE) &&
                        (r_vcount != c_VAL_FULL);
    // One slot is always kept back so an oversize packet can still store its tail.
    assign w_at_limit = (r_wcnt == c_WC_LIMIT);
    assign w_push     = r_in_pkt && w_is_tail;
    assign w_wr       = w_accept || w_push || (r_in_pkt && w_is_body && !w_at_limit);
    assign w_desc_bit = i_valid_wr && i_valid && !r_oversize;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
        if (w_push) r_vmem[r_vwr_ptr] <= w_desc_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_pkt   <= 1'b0;
            r_dropping <= 1'b0;
            r_oversize <= 1'b0;
            r_wcnt     <= '0;
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_is_head) begin
            r_in_pkt   <= w_accept;
            r_dropping <= !w_accept;
            r_oversize <= 1'b0;
            r_wcnt     <= c_WC_W'(1);
            if (!w_accept) r_drop_cnt <= r_drop_cnt + 32'd1;
        end else if (w_is_body || w_is_tail) begin
            if (r_in_pkt) begin
                if (w_is_tail) begin
                    r_in_pkt <= 1'b0;
                    if (r_oversize) r_err_cnt <= r_err_cnt + 32'd1;
                end else if (w_at_limit) begin
                    r_oversize <= 1'b1;
                end else begin
                    r_wcnt <= r_wcnt + c_WC_W'(1);
                end
            end else if (r_dropping) begin
                if (w_is_tail) r_dropping <= 1'b0;
            end else begin
                r_err_cnt <= r_err_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_vwr_ptr <= '0;
            r_vrd_ptr <= '0;
            r_vcount  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (i_rd_en) begin
                r_rd_ptr  <= r_rd_ptr + c_AW'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            if (w_wr && !i_rd_en)      r_count <= r_count + (c_AW+1)'(1);
            else if (!w_wr && i_rd_en) r_count <= r_count - (c_AW+1)'(1);
            if (w_push)     r_vwr_ptr <= r_vwr_ptr + c_VW'(1);
            if (i_desc_pop) r_vrd_ptr <= r_vrd_ptr + c_VW'(1);
            if (w_push && !i_desc_pop)      r_vcount <= r_vcount + (c_VW+1)'(1);
            else if (!w_push && i_desc_pop) r_vcount <= r_vcount - (c_VW+1)'(1);
        end
    end

    assign o_rd_data    = r_rd_data;
    assign o_rd_is_tail = (r_mem[r_rd_ptr][c_WORD_W-1 -: 2] == c_HDR_TAIL);
    assign o_desc_avail = (r_vcount != '0);
    assign o_desc_val   = r_vmem[r_vrd_ptr];
    assign o_drop_cnt   = r_drop_cnt;
    assign o_err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: rtl/esw_in_arb.sv
`default_nettype none
// ============================================================================
// Module   : esw_in_arb
// Purpose  : Two-input packet round-robin arbiter in front of the ESW ingress.
// Revision : 1.0
// ============================================================================
module esw_in_arb
    import esw_in_arb_pkg::*;
#(
    parameter int DATA_DEPTH    = 256,
    parameter int VAL_DEPTH     = 16,
    parameter int MAX_PKT_WORDS = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [133:0] in0_data,
    input  logic         in0_data_wr,
    input  logic         in0_valid,
    input  logic         in0_valid_wr,
    input  logic [133:0] in1_data,
    input  logic         in1_data_wr,
    input  logic         in1_valid,
    input  logic         in1_valid_wr,
    output logic [133:0] out_data,
    output logic         out_data_wr,
    output logic         out_valid,
    output logic         out_valid_wr,
    output logic [31:0]  drop_cnt0,
    output logic [31:0]  drop_cnt1,
    output logic [31:0]  err_cnt0,
    output logic [31:0]  err_cnt1,
    output logic [63:0]  pkt_out_cnt
);
    logic [c_WORD_W-1:0] w_in_data [2];
    logic [c_WORD_W-1:0] w_rd_data [2];
    logic [31:0]         w_drop_cnt [2];
    logic [31:0]         w_err_cnt [2];
    logic [1:0]          w_in_wr, w_in_valid, w_in_valid_wr;
    logic [1:0]          w_rd_en, w_desc_pop, w_is_tail, w_desc_avail, w_desc_val;

    assign w_in_data[0]  = in0_data;
    assign w_in_data[1]  = in1_data;
    assign w_in_wr       = {in1_data_wr, in0_data_wr};
    assign w_in_valid    = {in1_valid, in0_valid};
    assign w_in_valid_wr = {in1_valid_wr, in0_valid_wr};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_in
            esw_in_pkt_fifo #(
                .DATA_DEPTH    (DATA_DEPTH),
                .VAL_DEPTH     (VAL_DEPTH),
                .MAX_PKT_WORDS (MAX_PKT_WORDS)
            ) u_fifo (
                .clk          (clk),
                .rst          (rst),
                .i_data       (w_in_data[gi]),
                .i_data_wr    (w_in_wr[gi]),
                .i_valid      (w_in_valid[gi]),
                .i_valid_wr   (w_in_valid_wr[gi]),
                .i_rd_en      (w_rd_en[gi]),
                .i_desc_pop   (w_desc_pop[gi]),
                .o_rd_data    (w_rd_data[gi]),
                .o_rd_is_tail (w_is_tail[gi]),
                .o_desc_avail (w_desc_avail[gi]),
                .o_desc_val   (w_desc_val[gi]),
                .o_drop_cnt   (w_drop_cnt[gi]),
                .o_err_cnt    (w_err_cnt[gi])
            );
        end
    endgenerate

    arb_state_t    r_state, w_state_nxt;
    logic          r_grant, w_grant_nxt;
    logic          r_rr, w_rr_nxt;
    logic          w_pkt_done;
    logic          r_rd_vld, r_rd_src, r_rd_last, r_rd_desc;
    logic [133:0]  r_out_data;
    logic          r_out_data_wr, r_out_valid, r_out_valid_wr;
    logic [63:0]   r_pkt_out_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr;
        w_rd_en     = '0;
        w_desc_pop  = '0;
        w_pkt_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Waiting for the previous tail to leave the read stage keeps two idle output cycles.
                if (!r_rd_vld && (w_desc_avail != 2'b00)) begin
                    w_state_nxt = ST_SEND;
                    w_grant_nxt = (w_desc_avail == 2'b11) ? r_rr : w_desc_avail[1];
                end
            end
            ST_SEND: begin
                w_rd_en[r_grant] = 1'b1;
                if (w_is_tail[r_grant]) begin
                    w_desc_pop[r_grant] = 1'b1;
                    w_rr_nxt            = ~r_grant;
                    w_pkt_done          = 1'b1;
                    w_state_nxt         = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_grant        <= 1'b0;
            r_rr           <= 1'b0;
            r_rd_vld       <= 1'b0;
            r_rd_src       <= 1'b0;
            r_rd_last      <= 1'b0;
            r_rd_desc      <= 1'b0;
            r_out_data     <= '0;
            r_out_data_wr  <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_valid_wr <= 1'b0;
            r_pkt_out_cnt  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_grant        <= w_grant_nxt;
            r_rr           <= w_rr_nxt;
            r_rd_vld       <= (r_state == ST_SEND);
            r_rd_src       <= r_grant;
            r_rd_last      <= w_pkt_done;
            r_rd_desc      <= w_desc_val[r_grant];
            r_out_data     <= r_rd_vld ? w_rd_data[r_rd_src] : '0;
            r_out_data_wr  <= r_rd_vld;
            r_out_valid    <= r_rd_vld && r_rd_last && r_rd_desc;
            r_out_valid_wr <= r_rd_vld && r_rd_last;
            if (w_pkt_done) r_pkt_out_cnt <= r_pkt_out_cnt + 64'd1;
        end
    end

    assign out_data     = r_out_data;
    assign out_data_wr  = r_out_data_wr;
    assign out_valid    = r_out_valid;
    assign out_valid_wr = r_out_valid_wr;
    assign pkt_out_cnt  = r_pkt_out_cnt;
    assign drop_cnt0    = w_drop_cnt[0];
    assign drop_cnt1    = w_drop_cnt[1];
    assign err_cnt0     = w_err_cnt[0];
    assign err_cnt1     = w_err_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_esw_in_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_esw_in_arb
// Purpose  : Directed bench for esw_in_arb: vector table plus corner sequences.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_esw_in_arb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [133:0] in0_data = '0, in1_data = '0;
    logic         in0_data_wr = 1'b0, in0_valid = 1'b0, in0_valid_wr = 1'b0;
    logic         in1_data_wr = 1'b0, in1_valid = 1'b0, in1_valid_wr = 1'b0;
    logic [133:0] out_data;
    logic         out_data_wr, out_valid, out_valid_wr;
    logic [31:0]  drop_cnt0, drop_cnt1, err_cnt0, err_cnt1;
    logic [63:0]  pkt_out_cnt;

    esw_in_arb u_dut (
        .clk          (clk),
        .rst          (rst),
        .in0_data     (in0_data),
        .in0_data_wr  (in0_data_wr),
        .in0_valid    (in0_valid),
        .in0_valid_wr (in0_valid_wr),
        .in1_data     (in1_data),
        .in1_data_wr  (in1_data_wr),
        .in1_valid    (in1_valid),
        .in1_valid_wr (in1_valid_wr),
        .out_data     (out_data),
        .out_data_wr  (out_data_wr),
        .out_valid    (out_valid),
        .out_valid_wr (out_valid_wr),
        .drop_cnt0    (drop_cnt0),
        .drop_cnt1    (drop_cnt1),
        .err_cnt0     (err_cnt0),
        .err_cnt1     (err_cnt1),
        .pkt_out_cnt  (pkt_out_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [133:0] d; logic vwr; logic v; int c; } cap_t;
    cap_t capq[$];
    always @(negedge clk)
        if (out_data_wr || out_valid_wr) capq.push_back('{out_data, out_valid_wr, out_valid, cyc});

    int checks = 0;
    int errors = 0;
    int tail_in_cyc = 0;
    int head_cyc = 0;
    int tail_cyc = 0;
    longint exp_pkts = 0;
    int exp_err0 = 0, exp_err1 = 0;

    function automatic logic [133:0] mkword(input bit src, input int pid, input int idx, input int len);
        logic [1:0]  h;
        logic [31:0] t;
        h = (idx == 0) ? 2'b01 : ((idx == len - 1) ? 2'b10 : 2'b11);
        t = {8'(src), 8'(pid), 16'(idx)};
        return {h, 4'h0, t, ~t, t ^ 32'h5A5A_C3C3, t};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic send_pkt(input bit src, input int pid, input int len, input bit v);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (!src) begin
                in0_data = mkword(1'b0, pid, i, len); in0_data_wr = 1'b1;
                in0_valid = v; in0_valid_wr = (i == len - 1);
            end else begin
                in1_data = mkword(1'b1, pid, i, len); in1_data_wr = 1'b1;
                in1_valid = v; in1_valid_wr = (i == len - 1);
            end
            if (i == len - 1) tail_in_cyc = cyc + 1;
        end
        @(posedge clk); #1;
        if (!src) begin in0_data_wr = 1'b0; in0_valid_wr = 1'b0; end
        else      begin in1_data_wr = 1'b0; in1_valid_wr = 1'b0; end
    endtask

    // Pops one output packet and checks content, framing, valid flag and contiguity.
    task automatic expect_pkt(input string name, input bit src, input int pid,
                              input int in_len, input int out_len, input bit v);
        cap_t        e;
        logic [133:0] exp;
        bit          bad = 0;
        int          prev = 0;
        string       msg = "";
        for (int i = 0; i < 2000 && capq.size() < out_len; i++) @(posedge clk);
        checks++;
        if (capq.size() < out_len) begin
            errors++;
            $display("FAIL %s: got %0d words want %0d", name, capq.size(), out_len);
            capq.delete();
            return;
        end
        for (int k = 0; k < out_len; k++) begin
            e   = capq.pop_front();
            exp = mkword(src, pid, (k == out_len - 1) ? in_len - 1 : k, in_len);
            if (!bad && (e.d !== exp || e.vwr !== (k == out_len - 1) ||
                         (k == out_len - 1 && e.v !== v) || (k > 0 && e.c != prev + 1))) begin
                bad = 1;
                msg = $sformatf("word %0d got %h vwr=%b v=%b cyc=%0d want %h vwr=%b v=%b cyc=%0d",
                                k, e.d, e.vwr, e.v, e.c, exp, (k == out_len - 1), v, prev + 1);
            end
            if (k == 0) head_cyc = e.c;
            prev = e.c;
        end
        tail_cyc = prev;
        if (bad) begin
            errors++;
            $display("FAIL %s: %s", name, msg);
        end
    endtask

    typedef struct {
        bit src; int len; bit v; int out_len; bit out_v; int d_err0; int d_err1;
    } vec_t;
    vec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int prev_tail;
        tbl[0] = '{src: 1'b1, len: 4,   v: 1'b0, out_len: 4,   out_v: 1'b0, d_err0: 0, d_err1: 0};
        tbl[1] = '{src: 1'b1, len: 2,   v: 1'b1, out_len: 2,   out_v: 1'b1, d_err0: 0, d_err1: 0};
        tbl[2] = '{src: 1'b0, len: 128, v: 1'b1, out_len: 128, out_v: 1'b1, d_err0: 0, d_err1: 0};
        tbl[3] = '{src: 1'b0, len: 6,   v: 1'b1, out_len: 6,   out_v: 1'b1, d_err0: 0, d_err1: 0};
        tbl[4] = '{src: 1'b1, len: 129, v: 1'b1, out_len: 128, out_v: 1'b0, d_err0: 0, d_err1: 1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst out_data_wr", 64'(out_data_wr), 64'd0);
        chk("rst out_valid_wr", 64'(out_valid_wr), 64'd0);
        chk("rst out_data", 64'(out_data[63:0] | out_data[133:70]), 64'd0);
        chk("rst pkt_out_cnt", pkt_out_cnt, 64'd0);
        chk("rst drop_cnt", 64'({drop_cnt1, drop_cnt0}), 64'd0);
        chk("rst err_cnt", 64'({err_cnt1, err_cnt0}), 64'd0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (5) @(posedge clk);

        // Single good packet, latency T+3
        send_pkt(1'b0, 1, 4, 1'b1);
        expect_pkt("single4", 1'b0, 1, 4, 4, 1'b1);
        chk("latency", 64'(head_cyc), 64'(tail_in_cyc + 3));
        exp_pkts++;
        chk("single4 pkt_out_cnt", pkt_out_cnt, 64'(exp_pkts));

        // Vector table of isolated packets
        for (int i = 0; i < 5; i++) begin
            send_pkt(tbl[i].src, 100 + i, tbl[i].len, tbl[i].v);
            expect_pkt($sformatf("tbl%0d", i), tbl[i].src, 100 + i, tbl[i].len, tbl[i].out_len, tbl[i].out_v);
            repeat (6) @(posedge clk);
            exp_pkts++;
            exp_err0 += tbl[i].d_err0;
            exp_err1 += tbl[i].d_err1;
            chk($sformatf("tbl%0d pkt_out_cnt", i), pkt_out_cnt, 64'(exp_pkts));
            chk($sformatf("tbl%0d err_cnt0", i), 64'(err_cnt0), 64'(exp_err0));
            chk($sformatf("tbl%0d err_cnt1", i), 64'(err_cnt1), 64'(exp_err1));
            chk($sformatf("tbl%0d extra words", i), 64'(capq.size()), 64'd0);
        end

        // Three packets on each input at once: strict alternation 0,1,0,1,0,1
        fork
            begin send_pkt(1'b0, 10, 4, 1'b1); send_pkt(1'b0, 11, 4, 1'b1); send_pkt(1'b0, 12, 4, 1'b1); end
            begin send_pkt(1'b1, 20, 4, 1'b1); send_pkt(1'b1, 21, 4, 1'b1); send_pkt(1'b1, 22, 4, 1'b1); end
        join
        for (int p = 0; p < 6; p++) begin
            prev_tail = tail_cyc;
            expect_pkt($sformatf("rr%0d", p), p[0], (p[0] ? 20 : 10) + p / 2, 4, 4, 1'b1);
            if (p > 0) chk($sformatf("rr%0d gap", p), 64'(head_cyc - prev_tail >= 3), 64'd1);
        end
        exp_pkts += 6;
        repeat (6) @(posedge clk);
        chk("rr pkt_out_cnt", pkt_out_cnt, 64'(exp_pkts));

        // in0 fills up while output is busy with a 100-word in1 packet
        fork
            send_pkt(1'b1, 30, 100, 1'b1);
            begin
                repeat (5) @(posedge clk);
                send_pkt(1'b0, 31, 100, 1'b1);
                send_pkt(1'b0, 32, 100, 1'b1);
                send_pkt(1'b0, 33, 100, 1'b1);
            end
        join
        expect_pkt("fill in1", 1'b1, 30, 100, 100, 1'b1);
        expect_pkt("fill in0 a", 1'b0, 31, 100, 100, 1'b1);
        expect_pkt("fill in0 b", 1'b0, 32, 100, 100, 1'b1);
        repeat (20) @(posedge clk);
        exp_pkts += 3;
        chk("fill drop_cnt0", 64'(drop_cnt0), 64'd1);
        chk("fill drop_cnt1", 64'(drop_cnt1), 64'd0);
        chk("fill extra words", 64'(capq.size()), 64'd0);
        chk("fill pkt_out_cnt", pkt_out_cnt, 64'(exp_pkts));

        // Stray body word, then oversize packet on in0
        @(posedge clk); #1;
        in0_data = mkword(1'b0, 70, 1, 4); in0_data_wr = 1'b1;
        @(posedge clk); #1;
        in0_data_wr = 1'b0;
        repeat (10) @(posedge clk);
        chk("stray err_cnt0", 64'(err_cnt0), 64'd1);
        chk("stray no output", 64'(capq.size()), 64'd0);
        send_pkt(1'b0, 71, 130, 1'b1);
        expect_pkt("oversize", 1'b0, 71, 130, 128, 1'b0);
        repeat (6) @(posedge clk);
        exp_pkts++;
        chk("oversize err_cnt0", 64'(err_cnt0), 64'd2);
        chk("oversize pkt_out_cnt", pkt_out_cnt, 64'(exp_pkts));

        // Reset in the middle of a 10-word packet
        send_pkt(1'b0, 50, 10, 1'b1);
        for (int i = 0; i < 200 && capq.size() < 3; i++) @(posedge clk);
        chk("midrst started", 64'(capq.size() >= 3), 64'd1);
        #2; rst = 1'b1; #1;
        chk("midrst out_data_wr", 64'(out_data_wr), 64'd0);
        chk("midrst out_data", 64'(out_data[63:0] | out_data[133:70]), 64'd0);
        chk("midrst pkt_out_cnt", pkt_out_cnt, 64'd0);
        chk("midrst counters", 64'(drop_cnt0 | err_cnt0 | err_cnt1), 64'd0);
        repeat (2) @(posedge clk); #1; rst = 1'b0;
        capq.delete();
        repeat (20) @(posedge clk);
        chk("midrst abandoned", 64'(capq.size()), 64'd0);
        fork
            send_pkt(1'b0, 60, 3, 1'b1);
            send_pkt(1'b1, 61, 3, 1'b1);
        join
        expect_pkt("postrst in0 first", 1'b0, 60, 3, 3, 1'b1);
        expect_pkt("postrst in1", 1'b1, 61, 3, 3, 1'b1);
        repeat (6) @(posedge clk);
        chk("postrst pkt_out_cnt", pkt_out_cnt, 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
